// File: rtl/frame_dma.sv
// Frame-synchronised DMA engine: on every (cfg_div+1)-th vsync rising edge it runs one
// FILL, RAMP or COPY transfer of cfg_len beats over a simple req/ack bus.
module frame_dma #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vsync,
    input  logic [1:0]        cfg_mode,
    input  logic [ADDR_W-1:0] cfg_dst,
    input  logic [ADDR_W-1:0] cfg_src,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic [DATA_W-1:0] cfg_value,
    input  logic [3:0]        cfg_div,
    output logic              bus_req,
    output logic              bus_we,
    output logic              bus_re,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack,
    output logic              busy,
    output logic              done,
    output logic              overrun,
    output logic [7:0]        frame_count
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, FIN} state_t;

    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_FILL = 2'b01;
    localparam logic [1:0] MODE_RAMP = 2'b10;
    localparam logic [1:0] MODE_COPY = 2'b11;

    state_t            state_reg, state_next;
    logic              vsync_q;
    logic              arm_reg;
    logic [7:0]        frame_count_reg;
    logic [3:0]        div_cnt_reg;
    logic [1:0]        mode_reg;
    logic [ADDR_W-1:0] dst_reg, src_reg;
    logic [LEN_W-1:0]  len_reg;
    logic [DATA_W-1:0] value_reg;
    logic [7:0]        seed_reg;
    logic [LEN_W-1:0]  i_reg, i_next;
    logic [LEN_W:0]    i_inc;
    logic [DATA_W-1:0] rd_q;
    logic              load_cfg;
    logic              frame_event, trigger;
    logic              bus_req_reg, bus_req_next;
    logic              bus_we_reg, bus_we_next;
    logic              bus_re_reg, bus_re_next;
    logic [ADDR_W-1:0] bus_addr_reg, bus_addr_next;
    logic [DATA_W-1:0] bus_wdata_reg, bus_wdata_next;
    logic              done_reg, overrun_reg;

    function automatic logic [DATA_W-1:0] beat_data(
        input logic [1:0]        mode,
        input logic [DATA_W-1:0] value,
        input logic [7:0]        seed,
        input logic [LEN_W-1:0]  idx,
        input logic [DATA_W-1:0] rdata
    );
        case (mode)
            MODE_FILL: beat_data = value;
            MODE_RAMP: beat_data = value + DATA_W'(seed) + DATA_W'(idx);
            default:   beat_data = rdata;
        endcase
    endfunction

    function automatic logic [ADDR_W-1:0] beat_addr(
        input logic [ADDR_W-1:0] base,
        input logic [LEN_W-1:0]  idx
    );
        beat_addr = base + ADDR_W'(idx);
    endfunction

    // arm_reg masks the first cycle after reset so a vsync already high is not an edge.
    assign frame_event = vsync & ~vsync_q & arm_reg;
    assign trigger     = frame_event && (div_cnt_reg == cfg_div);
    assign i_inc       = {1'b0, i_reg} + 1'b1;

    always_comb begin
        state_next     = state_reg;
        i_next         = i_reg;
        load_cfg       = 1'b0;
        bus_req_next   = bus_req_reg;
        bus_we_next    = bus_we_reg;
        bus_re_next    = bus_re_reg;
        bus_addr_next  = bus_addr_reg;
        bus_wdata_next = bus_wdata_reg;
        case (state_reg)
            IDLE: begin
                if (trigger && cfg_mode != MODE_OFF) begin
                    load_cfg = 1'b1;
                    i_next   = {LEN_W{1'b0}};
                    if (cfg_len == {LEN_W{1'b0}}) begin
                        state_next = FIN;
                    end else if (cfg_mode == MODE_COPY) begin
                        state_next    = READ;
                        bus_req_next  = 1'b1;
                        bus_re_next   = 1'b1;
                        bus_we_next   = 1'b0;
                        bus_addr_next = cfg_src;
                    end else begin
                        state_next     = WRITE;
                        bus_req_next   = 1'b1;
                        bus_we_next    = 1'b1;
                        bus_re_next    = 1'b0;
                        bus_addr_next  = cfg_dst;
                        bus_wdata_next = beat_data(cfg_mode, cfg_value, frame_count_reg,
                                                   {LEN_W{1'b0}}, rd_q);
                    end
                end
            end
            READ: begin
                if (bus_ack) begin
                    state_next     = WRITE;
                    bus_re_next    = 1'b0;
                    bus_we_next    = 1'b1;
                    bus_addr_next  = beat_addr(dst_reg, i_reg);
                    bus_wdata_next = bus_rdata;
                end
            end
            WRITE: begin
                if (bus_ack) begin
                    if (i_inc < {1'b0, len_reg}) begin
                        i_next = i_inc[LEN_W-1:0];
                        if (mode_reg == MODE_COPY) begin
                            state_next    = READ;
                            bus_re_next   = 1'b1;
                            bus_we_next   = 1'b0;
                            bus_addr_next = beat_addr(src_reg, i_inc[LEN_W-1:0]);
                        end else begin
                            bus_addr_next  = beat_addr(dst_reg, i_inc[LEN_W-1:0]);
                            bus_wdata_next = beat_data(mode_reg, value_reg, seed_reg,
                                                       i_inc[LEN_W-1:0], rd_q);
                        end
                    end else begin
                        state_next   = FIN;
                        bus_req_next = 1'b0;
                        bus_we_next  = 1'b0;
                        bus_re_next  = 1'b0;
                    end
                end
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= IDLE;
            vsync_q         <= 1'b0;
            arm_reg         <= 1'b0;
            frame_count_reg <= 8'd0;
            div_cnt_reg     <= 4'd0;
            mode_reg        <= MODE_OFF;
            dst_reg         <= '0;
            src_reg         <= '0;
            len_reg         <= '0;
            value_reg       <= '0;
            seed_reg        <= 8'd0;
            i_reg           <= '0;
            rd_q            <= '0;
            bus_req_reg     <= 1'b0;
            bus_we_reg      <= 1'b0;
            bus_re_reg      <= 1'b0;
            bus_addr_reg    <= '0;
            bus_wdata_reg   <= '0;
            done_reg        <= 1'b0;
            overrun_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            vsync_q       <= vsync;
            arm_reg       <= 1'b1;
            i_reg         <= i_next;
            bus_req_reg   <= bus_req_next;
            bus_we_reg    <= bus_we_next;
            bus_re_reg    <= bus_re_next;
            bus_addr_reg  <= bus_addr_next;
            bus_wdata_reg <= bus_wdata_next;
            done_reg      <= (state_reg == FIN);
            // Divider and frame counter keep running even when the trigger is dropped.
            overrun_reg   <= trigger && (state_reg != IDLE);
            if (frame_event) begin
                frame_count_reg <= frame_count_reg + 8'd1;
                div_cnt_reg     <= (div_cnt_reg == cfg_div) ? 4'd0 : div_cnt_reg + 4'd1;
            end
            if (load_cfg) begin
                mode_reg  <= cfg_mode;
                dst_reg   <= cfg_dst;
                src_reg   <= cfg_src;
                len_reg   <= cfg_len;
                value_reg <= cfg_value;
                seed_reg  <= frame_count_reg;
            end
            if (state_reg == READ && bus_ack) begin
                rd_q <= bus_rdata;
            end
        end
    end

    assign bus_req     = bus_req_reg;
    assign bus_we      = bus_we_reg;
    assign bus_re      = bus_re_reg;
    assign bus_addr    = bus_addr_reg;
    assign bus_wdata   = bus_wdata_reg;
    assign busy        = (state_reg != IDLE);
    assign done        = done_reg;
    assign overrun     = overrun_reg;
    assign frame_count = frame_count_reg;

endmodule

// File: tb/tb_frame_dma.sv
// Directed bench for frame_dma: a req/ack bus slave with programmable latency logs each
// beat, and a linear sequence of steps checks transfers, divider, overrun and reset.
module tb_frame_dma;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 8;
    localparam int LEN_W  = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              vsync;
    logic [1:0]        cfg_mode;
    logic [ADDR_W-1:0] cfg_dst;
    logic [ADDR_W-1:0] cfg_src;
    logic [LEN_W-1:0]  cfg_len;
    logic [DATA_W-1:0] cfg_value;
    logic [3:0]        cfg_div;
    logic              bus_req, bus_we, bus_re;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_ack;
    logic              busy, done, overrun;
    logic [7:0]        frame_count;

    int tests = 0;
    int fails = 0;
    int ack_delay = 1;
    int wait_cnt = 0;
    int done_cnt = 0, ovr_cnt = 0, req_cycles = 0, busy_cycles = 0, busy_gap = 0;
    logic [ADDR_W-1:0] wr_addr[$];
    logic [DATA_W-1:0] wr_data[$];
    logic [ADDR_W-1:0] rd_addr[$];
    logic [7:0]        mem [0:4095];

    frame_dma #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset), .vsync(vsync),
        .cfg_mode(cfg_mode), .cfg_dst(cfg_dst), .cfg_src(cfg_src), .cfg_len(cfg_len),
        .cfg_value(cfg_value), .cfg_div(cfg_div),
        .bus_req(bus_req), .bus_we(bus_we), .bus_re(bus_re), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .busy(busy), .done(done), .overrun(overrun), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    // Bus slave: acks each beat ack_delay cycles after it is seen, logs one line per beat.
    always @(posedge clk) begin
        #1;
        if (!reset) begin
            bus_ack  = 1'b0;
            wait_cnt = 0;
        end else if (bus_ack) begin
            bus_ack  = 1'b0;
            wait_cnt = 0;
        end else if (bus_req) begin
            if (wait_cnt >= ack_delay) begin
                bus_ack = 1'b1;
                if (bus_re) begin
                    bus_rdata = mem[bus_addr];
                    rd_addr.push_back(bus_addr);
                    $display("[TB] beat rd addr=0x%03h data=0x%02h", bus_addr, bus_rdata);
                end else begin
                    wr_addr.push_back(bus_addr);
                    wr_data.push_back(bus_wdata);
                    $display("[TB] beat wr addr=0x%03h data=0x%02h", bus_addr, bus_wdata);
                end
            end else begin
                wait_cnt++;
            end
        end
    end

    always @(posedge clk) begin
        #2;
        if (done)              done_cnt++;
        if (overrun)           ovr_cnt++;
        if (bus_req)           req_cycles++;
        if (busy)              busy_cycles++;
        if (bus_req && !busy)  busy_gap++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic vsync_pulse();
        @(negedge clk) vsync = 1'b1;
        @(negedge clk) vsync = 1'b0;
    endtask

    task automatic clear_logs();
        wr_addr.delete();
        wr_data.delete();
        rd_addr.delete();
    endtask

    task automatic run_until_done(input int budget, input string tag);
        int start;
        int n;
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, (done_cnt != start) ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin
        logic [ADDR_W-1:0] copy_addr [4];
        logic [DATA_W-1:0] copy_data [4];
        int d0, o0, r0, b0;
        copy_addr = '{12'h7FE, 12'h7FF, 12'h800, 12'h801};
        copy_data = '{8'h11, 8'h22, 8'h33, 8'h44};
        mem[12'h100] = 8'h11;
        mem[12'h101] = 8'h22;
        mem[12'h102] = 8'h33;
        mem[12'h103] = 8'h44;

        reset = 1'b0; vsync = 1'b1; cfg_mode = 2'b00; cfg_dst = '0; cfg_src = '0;
        cfg_len = '0; cfg_value = '0; cfg_div = 4'd0; bus_rdata = '0; bus_ack = 1'b0;

        // Reset state, with vsync held high across release.
        repeat (3) @(negedge clk);
        check("rst_ctrl", {26'd0, bus_req, bus_we, bus_re, busy, done, overrun}, 32'd0);
        check("rst_addr", bus_addr, 32'd0);
        check("rst_wdata", bus_wdata, 32'd0);
        check("rst_frame_count", frame_count, 32'd0);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check("vsync_high_at_release", frame_count, 32'd0);
        vsync = 1'b0;
        @(negedge clk);

        // Mode OFF: frame counted, nothing else.
        d0 = done_cnt;
        vsync_pulse();
        repeat (6) @(negedge clk);
        check("off_frame_count", frame_count, 32'd1);
        check("off_no_done", done_cnt - d0, 32'd0);
        check("off_no_req", req_cycles, 32'd0);

        // FILL 0xAA to 0x400..0x403.
        cfg_mode = 2'b01; cfg_dst = 12'h400; cfg_len = 8'd4; cfg_value = 8'hAA;
        clear_logs();
        d0 = done_cnt;
        vsync_pulse();
        run_until_done(100, "fill");
        check("fill_beats", wr_addr.size(), 32'd4);
        for (int k = 0; k < 4 && k < wr_addr.size(); k++) begin
            check($sformatf("fill_addr%0d", k), wr_addr[k], 32'h400 + k);
            check($sformatf("fill_data%0d", k), wr_data[k], 32'hAA);
        end
        repeat (4) @(negedge clk);
        check("fill_done_once", done_cnt - d0, 32'd1);
        check("fill_busy_gap", busy_gap, 32'd0);
        check("fill_idle_ctrl", {29'd0, bus_req, bus_we, bus_re}, 32'd0);
        check("fill_addr_hold", bus_addr, 32'h403);
        check("fill_wdata_hold", bus_wdata, 32'hAA);
        check("fill_frame_count", frame_count, 32'd2);

        // Advance frame_count to 5 with mode OFF, then RAMP.
        cfg_mode = 2'b00;
        repeat (3) begin
            vsync_pulse();
            repeat (2) @(negedge clk);
        end
        check("ramp_pre_frame_count", frame_count, 32'd5);
        cfg_mode = 2'b10; cfg_dst = 12'h200; cfg_len = 8'd3; cfg_value = 8'h10;
        clear_logs();
        vsync_pulse();
        run_until_done(100, "ramp1");
        check("ramp1_beats", wr_data.size(), 32'd3);
        for (int k = 0; k < 3 && k < wr_data.size(); k++)
            check($sformatf("ramp1_data%0d", k), wr_data[k], 32'h15 + k);
        clear_logs();
        vsync_pulse();
        run_until_done(100, "ramp2");
        check("ramp2_first_data", (wr_data.size() > 0) ? {24'd0, wr_data[0]} : 32'hDEAD, 32'h16);

        // COPY 0x100.. -> 0x7FE.. crossing 0x800.
        cfg_mode = 2'b11; cfg_src = 12'h100; cfg_dst = 12'h7FE; cfg_len = 8'd4;
        clear_logs();
        vsync_pulse();
        run_until_done(150, "copy");
        check("copy_reads", rd_addr.size(), 32'd4);
        check("copy_beats", wr_addr.size(), 32'd4);
        for (int k = 0; k < 4 && k < wr_addr.size(); k++) begin
            check($sformatf("copy_addr%0d", k), wr_addr[k], copy_addr[k]);
            check($sformatf("copy_data%0d", k), wr_data[k], copy_data[k]);
        end
        for (int k = 0; k < 4 && k < rd_addr.size(); k++)
            check($sformatf("copy_raddr%0d", k), rd_addr[k], 32'h100 + k);

        // Address wrap at the top of the space.
        cfg_dst = 12'hFFF; cfg_len = 8'd2;
        clear_logs();
        vsync_pulse();
        run_until_done(100, "wrap");
        check("wrap_beats", wr_addr.size(), 32'd2);
        if (wr_addr.size() == 2) begin
            check("wrap_addr0", wr_addr[0], 32'hFFF);
            check("wrap_addr1", wr_addr[1], 32'h000);
            check("wrap_data1", wr_data[1], 32'h22);
        end

        // Divider 2: six events -> transfers on events 3 and 6.
        @(negedge clk) reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        cfg_mode = 2'b01; cfg_div = 4'd2; cfg_len = 8'd1; cfg_dst = 12'h010; cfg_value = 8'h5A;
        clear_logs();
        for (int e = 1; e <= 6; e++) begin
            vsync_pulse();
            repeat (8) @(negedge clk);
            if (e == 2) check("div_after_ev2", wr_addr.size(), 32'd0);
            if (e == 3) check("div_after_ev3", wr_addr.size(), 32'd1);
            if (e == 5) check("div_after_ev5", wr_addr.size(), 32'd1);
        end
        check("div_transfers", wr_addr.size(), 32'd2);
        check("div_frame_count", frame_count, 32'd6);

        // len = 0: one busy cycle and a done pulse, no bus beat.
        cfg_div = 4'd0; cfg_len = 8'd0;
        d0 = done_cnt; r0 = req_cycles; b0 = busy_cycles;
        vsync_pulse();
        run_until_done(20, "len0");
        repeat (3) @(negedge clk);
        check("len0_no_req", req_cycles - r0, 32'd0);
        check("len0_busy_cycles", busy_cycles - b0, 32'd1);
        check("len0_done_once", done_cnt - d0, 32'd1);

        // len = 8, slow slave, second frame event mid-transfer.
        ack_delay = 20;
        cfg_len = 8'd8; cfg_dst = 12'h300; cfg_value = 8'h77;
        clear_logs();
        d0 = done_cnt; o0 = ovr_cnt;
        vsync_pulse();
        repeat (30) @(negedge clk);
        vsync_pulse();
        run_until_done(400, "ovr");
        repeat (40) @(negedge clk);
        check("ovr_pulses", ovr_cnt - o0, 32'd1);
        check("ovr_beats", wr_addr.size(), 32'd8);
        check("ovr_done_once", done_cnt - d0, 32'd1);
        check("ovr_last_addr", (wr_addr.size() == 8) ? {20'd0, wr_addr[7]} : 32'hDEAD, 32'h307);

        // Reset asserted mid-beat, between clock edges.
        clear_logs();
        vsync_pulse();
        repeat (10) @(negedge clk);
        check("midbeat_req_before", bus_req, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("midbeat_ctrl", {26'd0, bus_req, bus_we, bus_re, busy, done, overrun}, 32'd0);
        check("midbeat_addr", bus_addr, 32'd0);
        check("midbeat_wdata", bus_wdata, 32'd0);
        check("midbeat_frame_count", frame_count, 32'd0);
        r0 = req_cycles;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (30) @(negedge clk);
        check("midbeat_no_req_after", req_cycles - r0, 32'd0);
        check("midbeat_no_writes", wr_addr.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/frame_dma.md
FRAME_DMA -- requirements
Module: frame_dma

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 12, bus address width.
REQ-002 The block SHALL have parameter DATA_W, default 8, bus data width.
REQ-003 The block SHALL have parameter LEN_W, default 8, transfer length width.
REQ-004 Ports SHALL be, in order:
- clk  in  1  single system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- vsync  in  1  frame strobe, clk-domain; the rising edge is the frame event.
- cfg_mode  in  2  00 OFF, 01 FILL, 10 RAMP, 11 COPY.
- cfg_dst  in  ADDR_W  destination base address.
- cfg_src  in  ADDR_W  source base address (COPY only).
- cfg_len  in  LEN_W  beat count.
- cfg_value  in  DATA_W  FILL constant / RAMP seed offset.
- cfg_div  in  4  frame divider; run every cfg_div+1 frames.
- bus_req  out  1  bus request, held for the whole beat.
- bus_we  out  1  write strobe.
- bus_re  out  1  read strobe.
- bus_addr  out  ADDR_W  beat address.
- bus_wdata  out  DATA_W  write data.
- bus_rdata  in  DATA_W  read data, valid with bus_ack on reads.
- bus_ack  in  1  beat completion, one cycle.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse at transfer end.
- overrun  out  1  one-cycle pulse, frame event lost while busy.
- frame_count  out  8  count of frame events.

Function
REQ-005 Frame event: vsync registered once; event = vsync & ~vsync_q; frame_count increments by 1 per event, wrapping 255->0.
REQ-006 Divider: 4-bit counter div_cnt; on each event, if div_cnt == cfg_div, trigger and clear div_cnt, else increment div_cnt; counts in every mode including OFF.
REQ-007 Trigger in IDLE with cfg_mode != OFF SHALL latch all cfg_* and seed = frame_count, clear beat index i, and enter the next state on the following edge.
REQ-008 Trigger in IDLE with cfg_mode == OFF SHALL be ignored, with no done pulse.
REQ-009 States SHALL be IDLE, READ, WRITE, FIN.
- IDLE->READ on trigger with COPY.
- IDLE->WRITE on trigger with FILL or RAMP.
- READ->WRITE on bus_ack.
- WRITE->READ (COPY) or WRITE (FILL/RAMP) on bus_ack when i+1 < len.
- WRITE->FIN on bus_ack when i+1 == len.
- FIN->IDLE unconditionally.
REQ-010 Latched len == 0 SHALL go IDLE->FIN directly, with zero bus beats.
REQ-011 READ SHALL drive bus_req=1, bus_re=1, bus_we=0, bus_addr=src+i mod 2^ADDR_W, and capture bus_rdata into rd_q on bus_ack.
REQ-012 WRITE SHALL drive bus_req=1, bus_we=1, bus_re=0, bus_addr=dst+i mod 2^ADDR_W, with bus_wdata per mode.
- FILL: value.
- RAMP: (seed+value+i) mod 2^DATA_W.
- COPY: rd_q.
REQ-013 Bus outputs SHALL be registered and held stable until bus_ack; a beat never times out.
REQ-014 In IDLE and FIN, bus_req, bus_we and bus_re SHALL be 0; bus_addr and bus_wdata hold their last values.
REQ-015 busy SHALL be 1 in READ, WRITE and FIN; done SHALL be 1 exactly in the cycle after FIN, coincident with the return to IDLE.
REQ-016 A trigger while busy=1 SHALL be dropped, pulse overrun for one cycle, and not be queued; frame_count and div_cnt still advance.
REQ-017 cfg_* changes while busy SHALL have no effect on the running transfer.
REQ-018 bus_ack outside READ/WRITE SHALL be ignored.

Reset
REQ-019 reset low SHALL immediately force the following, regardless of state, including mid-beat:
- state IDLE.
- bus_req, bus_we, bus_re, busy, done, overrun = 0.
- bus_addr, bus_wdata, frame_count, div_cnt, i, rd_q, vsync_q = 0.
REQ-020 After reset release, the first vsync rising edge SHALL be the first frame event; a vsync held high at release SHALL not generate an event.

Verification
REQ-021 FILL, dst=0x400, len=4, value=0xAA, div=0, ack one cycle after req -> writes 0xAA to 0x400..0x403, done once, busy 1 throughout.
REQ-022 RAMP, frame_count=5 at trigger, value=0x10, len=3 -> wdata 0x15,0x16,0x17; next frame's run starts at 0x16.
REQ-023 COPY, src=0x100, dst=0x7FE, len=4, ADDR_W=12, rdata = 0x11,0x22,0x33,0x44 -> writes in order to 0x7FE,0x7FF,0x800,0x801; address wrap verified separately with dst=0xFFF -> 0xFFF,0x000.
REQ-024 div=2, six vsync pulses, FILL len=1 -> exactly two transfers, on events 3 and 6; frame_count=6.
REQ-025 len=0 -> no bus_req, busy for one cycle, done pulse; mode OFF -> nothing, no done.
REQ-026 len=8 with ack delayed 20 cycles, vsync event mid-transfer -> one overrun pulse, transfer completes unaffected; reset asserted mid-beat -> all outputs 0 asynchronously, no further bus activity.
